// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port integer register file.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_IDLE  = 1'b1
  } rf_state_t;

  localparam int unsigned XLEN_DEF  = 64;
  localparam int unsigned NREGS_DEF = 32;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every register index once, writing zero, after reset or on request.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      RF_CLEAR: begin
        if (clr_idx_q == AW'(NREGS - 1)) begin
          state_d   = RF_IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + AW'(1);
        end
      end
      RF_IDLE: begin
        if (clr_req) begin
          state_d   = RF_CLEAR;
          clr_idx_d = '0;
        end
      end
      default: begin
        state_d   = RF_CLEAR;
        clr_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RF_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  assign busy     = (state_q == RF_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = clr_idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with hardwired zero, write-first bypass
// and a hardware clear sequencer.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN     = XLEN_DEF,
  parameter  int unsigned NREGS    = NREGS_DEF,
  parameter  int unsigned NRD      = 2,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned AW       = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic                clr_req,
  output logic                busy
);

  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic            port_we;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_q [NREGS];

  regfile_clear_seq #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // A clear request in IDLE wins over a same-cycle port write.
  always_comb begin
    port_we   = wr_en && !busy && !clr_req && !((ZERO_REG != 0) && (wr_addr == '0));
    mem_we    = clr_we || port_we;
    mem_waddr = clr_we ? clr_addr : wr_addr;
    mem_wdata = clr_we ? '0 : wr_data;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd_val;

    assign ra = rd_addr[k*AW +: AW];

    always_comb begin
      rd_val = mem_q[ra];
      if (busy || ((ZERO_REG != 0) && (ra == '0))) begin
        rd_val = '0;
      end else if (port_we && (ra == wr_addr)) begin
        rd_val = wr_data;
      end
    end

    assign rd_data[k*XLEN +: XLEN] = rd_val;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Drives three register-file builds with shared stimulus and checks them against a reference model.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        clr_req = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [4:0]  ra [3] = '{5'd0, 5'd0, 5'd0};
  logic        rst_next = 1'b0;

  logic [9:0]   rda_a;
  logic [11:0]  rda_b;
  logic [127:0] rd0, rd1;
  logic [95:0]  rd2;
  logic         busy0, busy1, busy2;

  assign rda_a = {ra[1], ra[0]};
  assign rda_b = {ra[2][3:0], ra[1][3:0], ra[0][3:0]};

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(64), .NREGS(32), .NRD(2), .ZERO_REG(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rda_a), .rd_data(rd0), .clr_req(clr_req), .busy(busy0)
  );

  regfile_mp #(.XLEN(64), .NREGS(32), .NRD(2), .ZERO_REG(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rda_a), .rd_data(rd1), .clr_req(clr_req), .busy(busy1)
  );

  regfile_mp #(.XLEN(32), .NREGS(16), .NRD(3), .ZERO_REG(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr[3:0]), .wr_data(wr_data[31:0]),
    .rd_addr(rda_b), .rd_data(rd2), .clr_req(clr_req), .busy(busy2)
  );

  // Reference model: per build, register contents and cycles of clearing still owed.
  logic [63:0] m [3][32];
  int          clr_left [3];
  int          nb [3];
  int          nregs [3] = '{32, 32, 16};
  int          nports [3] = '{2, 2, 3};
  bit          zr [3] = '{1'b1, 1'b0, 1'b1};
  logic [63:0] dmask [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF};
  int          total = 0;
  int          bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_rd(input int d, input logic [4:0] a);
    int aa = int'(a) % nregs[d];
    int wa = int'(wr_addr) % nregs[d];
    if (clr_left[d] > 0) return '0;
    if (zr[d] && aa == 0) return '0;
    if (wr_en && !clr_req && !(zr[d] && wa == 0) && aa == wa) return wr_data & dmask[d];
    return m[d][aa];
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      int wa = int'(wr_addr) % nregs[d];
      if (!rst_n) begin
        clr_left[d] = nregs[d];
      end else if (clr_left[d] > 0) begin
        m[d][nregs[d] - clr_left[d]] = '0;
        clr_left[d]--;
      end else if (clr_req) begin
        clr_left[d] = nregs[d];
      end else if (wr_en && !(zr[d] && wa == 0)) begin
        m[d][wa] = wr_data & dmask[d];
      end
    end
  endtask

  task automatic cyc(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                     input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                     input logic cr);
    logic [63:0] got;
    @(posedge clk);
    model_edge();
    #1;
    rst_n   = rst_next;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    ra[0]   = a0;
    ra[1]   = a1;
    ra[2]   = a2;
    clr_req = cr;
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) clr_left[d] = nregs[d];
    end
    @(negedge clk);
    check("busy0", {63'd0, busy0}, {63'd0, clr_left[0] > 0});
    check("busy1", {63'd0, busy1}, {63'd0, clr_left[1] > 0});
    check("busy2", {63'd0, busy2}, {63'd0, clr_left[2] > 0});
    nb[0] += int'(busy0);
    nb[1] += int'(busy1);
    nb[2] += int'(busy2);
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < nports[d]; k++) begin
        if (d == 0) got = rd0[k*64 +: 64];
        else if (d == 1) got = rd1[k*64 +: 64];
        else got = {32'd0, rd2[k*32 +: 32]};
        check($sformatf("rd_d%0d_p%0d_a%0d", d, k, ra[k]), got, exp_rd(d, ra[k]));
      end
    end
  endtask

  task automatic idle_sweep(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 5'd0, 64'd0, 5'(i), 5'(i + 1), 5'(i + 2), 1'b0);
    end
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 3; d++) nb[d] = 0;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      clr_left[d] = nregs[d];
      for (int r = 0; r < 32; r++) m[d][r] = 'x;
    end

    // Reset, then release: busy must last exactly NREGS cycles, then all regs read zero.
    rst_next = 1'b0;
    idle_sweep(3);
    rst_next = 1'b1;
    clear_counts();
    idle_sweep(70);
    check("busy_len_rst_32", 64'(nb[0]), 64'd32);
    check("busy_len_rst_16", 64'(nb[2]), 64'd16);

    // Write then read back; bypass with a neighbouring stale read; zero register handling.
    cyc(1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc(1'b0, 5'd0, 64'd0, 5'd5, 5'd5, 5'd5, 1'b0);
    cyc(1'b1, 5'd8, 64'h1234_5678_9ABC_DEF0, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc(1'b1, 5'd7, 64'hA5, 5'd7, 5'd8, 5'd7, 1'b0);
    cyc(1'b1, 5'd0, 64'hFFFF, 5'd0, 5'd7, 5'd0, 1'b0);
    cyc(1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 5'd8, 1'b0);

    // Fill with nonzero data, then a clear request colliding with a write.
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, 5'(i), {$urandom, $urandom} | 64'h1, 5'(i), 5'(i + 3), 5'(i), 1'b0);
    end
    cyc(1'b1, 5'd3, 64'hCAFE_F00D, 5'd3, 5'd4, 5'd3, 1'b1);
    clear_counts();
    idle_sweep(40);
    check("busy_len_req_32", 64'(nb[0]), 64'd32);
    check("busy_len_req_16", 64'(nb[2]), 64'd16);

    // Random traffic with occasional clear requests and reset pulses.
    for (int i = 0; i < 500; i++) begin
      rst_next = ($urandom_range(0, 249) != 0);
      cyc(1'($urandom), 5'($urandom), {$urandom, $urandom}, 5'($urandom), 5'($urandom),
          5'($urandom), $urandom_range(0, 59) == 0);
    end
    rst_next = 1'b1;
    idle_sweep(40);

    // Reset ten cycles into a clear: the clear restarts and runs its full length.
    cyc(1'b0, 5'd0, 64'd0, 5'd1, 5'd2, 5'd3, 1'b1);
    idle_sweep(10);
    rst_next = 1'b0;
    idle_sweep(2);
    rst_next = 1'b1;
    clear_counts();
    idle_sweep(40);
    check("busy_len_midrst_32", 64'(nb[0]), 64'd32);
    check("busy_len_midrst_16", 64'(nb[2]), 64'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
